opb_register_bank_simulink2ppc: RTL
===================================

# opb_register_bank_simulink2ppc

Parametrised OPB slave register bank: the multi-channel successor to the single-word simulink-to-PPC software register. It exposes N_CHAN 32-bit user words to the PowerPC over OPB. The user words are captured coherently into a shadow bank, either by a fabric strobe or by a software request, so that all channels read back from the same cycle. It sits on the OPB bus alongside the other software registers, in the OPB clock domain.

## Interface
- C_BASEADDR, 32'h01008600: first byte address of the bank.
- C_HIGHADDR, 32'h010086FF: last byte address of the bank; the decode window must cover 0x10 + 4*N_CHAN bytes.
- N_CHAN, 4: number of user channels, 1..32.
- LIVE_MODE, 0: when 1, channel reads return user_data_in directly (registered) and capture is ignored.
- OPB_Clk  in  1  sole clock; the bus and user_data_in are synchronous to it.
- OPB_Rst_n  in  1  reset; synchronous, active-low.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers register bits 31:24.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero except during the ack cycle.
- Sl_xferAck  out  1  transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1  each tied 0.
- user_data_in  in  [32*N_CHAN-1:0]  channel i occupies bits [32i+31:32i].
- user_strobe  in  1  single-cycle capture request from fabric.
- snap_valid  out  1  the shadow bank holds an unacknowledged capture.

## Operation
- Register map, as byte offsets from C_BASEADDR:
  - 0x00 CTRL. Write bit31 = capture request; bit30 = clear overrun; bit29 = acknowledge (clears snap_valid). A write takes effect only when BE[0]=1. Reads return 0.
  - 0x04 STATUS. Bit31 = snap_valid; bit30 = overrun (sticky); bits 15:0 = capture count, which wraps at 0xFFFF→0.
  - 0x08 TIMESTAMP. Present only when the macro is defined; otherwise reads 0.
  - 0x10+4i CHAN[i].
- Unmapped offsets inside the window ack normally, read 0 and ignore writes. Addresses outside the window are ignored with no ack.
- Bit mapping: register bit k ↔ Sl_DBus/OPB_DBus[31-k].
- Capture:
  - Triggered by user_strobe=1, or by a CTRL bit31 write (effective on its ack cycle). Both in the same cycle count as one capture.
  - Effect: all channels are copied into the shadow bank, count increments by 1, and snap_valid is set.
  - A capture while snap_valid=1 still captures and also sets overrun.
- Same-cycle acknowledge and capture: the capture wins, so snap_valid=1 and overrun is not set.
- Same-cycle clear-overrun and overrun-setting capture: overrun=1.
- LIVE_MODE=1: CHAN[i] = user_data_in sampled in the cycle OPB_select is first seen. Capture still updates count and snap_valid.
- Bus FSM states:
  - IDLE: on select with an in-window address → ACK.
  - ACK: Sl_xferAck=1 for one cycle, read data driven, write committed → WAIT.
  - WAIT: stay until select=0 → IDLE.
  - If select drops in IDLE before ack, nothing happens.
- Reset (OPB_Rst_n=0 at a clock edge) values:
  - FSM in IDLE.
  - Sl_xferAck=0, Sl_DBus=0.
  - Shadow bank 0, count 0, overrun 0, snap_valid=0, timestamp 0.
  - A transfer in flight is dropped with no ack.

## Timing
- Read and write latency: Sl_xferAck is asserted exactly 2 edges after OPB_select rises (decode register, then ack). Read data is valid in the same cycle as the ack.
- Capture latency: the shadow bank holds user_data_in as sampled at the strobe edge. The capture is visible to a read whose ack occurs ≥1 cycle after the strobe cycle.
- snap_valid rises on the edge after the strobe.
- Minimum spacing between transfers: one idle cycle (WAIT→IDLE).
- All outputs are registered.

## Configuration
- OPB_REGBANK_TIMESTAMP_EN defined:
  - A free-running 32-bit cycle counter is present; it resets to 0 and wraps.
  - Its value is latched into TIMESTAMP on every capture.
- OPB_REGBANK_TIMESTAMP_EN not defined:
  - No counter and no latch are instantiated.
  - TIMESTAMP reads 0.

## Structure
- Shared package holds:
  - register offset constants (CTRL, STATUS, TIMESTAMP, CHAN_BASE);
  - CTRL bit indices;
  - the bus FSM state enum;
  - a bit-reversal function for OPB ordering.
- One sub-module, opb_slave_decode: address window check, FSM and ack generation. It outputs a registered offset, a write strobe and a read strobe.

## Test plan
- Reset, then read STATUS: Sl_DBus=0x00000000, and ack arrives 2 cycles after select.
- user_data_in={32'hDEADBEEF, …, 32'h00000001}, pulse user_strobe, then change the inputs. CHAN[0] reads 0x00000001 and CHAN[N_CHAN-1] reads 0xDEADBEEF. STATUS reads 0x80000001.
- Second strobe without acknowledge: STATUS bit30=1 and count=2. Write CTRL=0x60000000: STATUS reads 0x00000002.
- Write CTRL=0x80000000 with BE=4'b0111: no capture. Repeat with BE=4'b1111: count increments.
- Assert OPB_Rst_n=0 during ACK: no ack is seen, and all registers read 0 afterwards.
- With OPB_REGBANK_TIMESTAMP_EN defined, strobe at cycle 100 after reset: TIMESTAMP reads 100.

Source files
------------

// File: rtl/opb_register_bank_simulink2ppc_pkg.sv
// Shared definitions for the OPB register bank: register map offsets,
// CTRL bit positions, bus FSM states and OPB bit-order conversion helpers.
// OPB numbers bits MSB-first ([0:31]); register bit k lives on bus bit 31-k.
package opb_register_bank_simulink2ppc_pkg;

  localparam logic [31:0] OFF_CTRL      = 32'h00;
  localparam logic [31:0] OFF_STATUS    = 32'h04;
  localparam logic [31:0] OFF_TIMESTAMP = 32'h08;
  localparam logic [31:0] OFF_CHAN_BASE = 32'h10;

  localparam int CTRL_CAPTURE = 31;
  localparam int CTRL_CLR_OVR = 30;
  localparam int CTRL_ACK     = 29;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } bus_state_t;

  function automatic logic [31:0] opb_to_reg(input logic [0:31] b);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = b[31-k];
    return r;
  endfunction

  function automatic logic [0:31] reg_to_opb(input logic [31:0] r);
    logic [0:31] b;
    for (int k = 0; k < 32; k++) b[31-k] = r[k];
    return b;
  endfunction

endpackage

// File: rtl/opb_register_bank_simulink2ppc_if.sv
// OPB slave-side signal bundle. The master modport drives address/data/
// control; the slave modport returns read data and the acknowledge lines.
// All buses keep OPB MSB-first [0:n] numbering.
interface opb_register_bank_simulink2ppc_if;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw;
  logic        select;
  logic        seq_addr;
  logic [0:31] sl_dbus;
  logic        xfer_ack;
  logic        err_ack;
  logic        retry;
  logic        tout_sup;

  modport master (
    output abus, be, dbus, rnw, select, seq_addr,
    input  sl_dbus, xfer_ack, err_ack, retry, tout_sup
  );

  modport slave (
    input  abus, be, dbus, rnw, select, seq_addr,
    output sl_dbus, xfer_ack, err_ack, retry, tout_sup
  );
endinterface

// File: rtl/opb_slave_decode.sv
// OPB slave address decode and transfer FSM (IDLE -> ACK -> WAIT).
// Latency: decode register on the first edge, xfer_ack on the second.
// One transfer at a time; WAIT holds until select drops, forcing an idle cycle.
module opb_slave_decode
  import opb_register_bank_simulink2ppc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h01008600,
  parameter logic [31:0] C_HIGHADDR = 32'h010086FF
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  opb_register_bank_simulink2ppc_if.slave        opb,
  output logic                                   accept,
  output logic [31:0]                            offset,
  output logic [3:0]                             be,
  output logic [31:0]                            wdata,
  output logic                                   wr_stb,
  output logic                                   rd_stb
);

  bus_state_t  state, state_nx;
  logic        rnw_q;
  logic [31:0] addr;
  logic        in_win;

  assign addr   = opb_to_reg(opb.abus);
  assign in_win = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state: accept an in-window select, ack once, wait for select release
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (opb.select && in_win) state_nx = ST_ACK;
      ST_ACK:  state_nx = ST_WAIT;
      ST_WAIT: if (!opb.select) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs: accept on entry, read/write strobes during the ACK state
  always_comb begin
    accept = (state == ST_IDLE) && opb.select && in_win;
    wr_stb = (state == ST_ACK) && !rnw_q;
    rd_stb = (state == ST_ACK) &&  rnw_q;
  end

  // Latch the transfer attributes when it is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      offset <= '0;
      be     <= '0;
      wdata  <= '0;
      rnw_q  <= 1'b0;
    end else if (accept) begin
      offset <= addr - C_BASEADDR;
      be     <= {opb.be[0], opb.be[1], opb.be[2], opb.be[3]};
      wdata  <= opb_to_reg(opb.dbus);
      rnw_q  <= opb.rnw;
    end
  end

  // Registered acknowledge, high for exactly the cycle after the ACK state
  always_ff @(posedge clk) begin
    if (!rst_n) opb.xfer_ack <= 1'b0;
    else        opb.xfer_ack <= (state == ST_ACK);
  end

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// Multi-channel OPB register bank: coherent shadow capture of N_CHAN user words.
// Latency: ack and read data two edges after select; capture visible next cycle.
// Optional OPB_REGBANK_TIMESTAMP_EN adds a cycle counter latched on capture.
module opb_register_bank_simulink2ppc
  import opb_register_bank_simulink2ppc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h01008600,
  parameter logic [31:0] C_HIGHADDR = 32'h010086FF,
  parameter int          N_CHAN     = 4,
  parameter bit          LIVE_MODE  = 1'b0
) (
  input  logic                                   OPB_Clk,
  input  logic                                   OPB_Rst_n,
  opb_register_bank_simulink2ppc_if.slave        opb,
  input  logic [32*N_CHAN-1:0]                   user_data_in,
  input  logic                                   user_strobe,
  output logic                                   snap_valid
);

  logic                  accept, wr_stb, rd_stb;
  logic [31:0]           offset, wdata;
  logic [3:0]            be;
  logic                  ctrl_wr, capture, ack_req, clr_req;
  logic                  overrun;
  logic [15:0]           count;
  logic [32*N_CHAN-1:0]  shadow, chan_src;
  logic [31:0]           ts_rd, rdata;
  logic                  unused_bits;

  opb_slave_decode #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_decode (
    .clk    (OPB_Clk),
    .rst_n  (OPB_Rst_n),
    .opb    (opb),
    .accept (accept),
    .offset (offset),
    .be     (be),
    .wdata  (wdata),
    .wr_stb (wr_stb),
    .rd_stb (rd_stb)
  );

  assign opb.err_ack  = 1'b0;
  assign opb.retry    = 1'b0;
  assign opb.tout_sup = 1'b0;

  // Only the top byte of CTRL carries control bits; the rest is don't-care
  assign unused_bits = ^{accept, be[2:0], wdata[28:0], opb.seq_addr};

  // CTRL write decode; a fabric strobe and a software request merge into one capture
  always_comb begin
    ctrl_wr = wr_stb && (offset == OFF_CTRL) && be[3];
    capture = user_strobe || (ctrl_wr && wdata[CTRL_CAPTURE]);
    ack_req = ctrl_wr && wdata[CTRL_ACK];
    clr_req = ctrl_wr && wdata[CTRL_CLR_OVR];
  end

  // Capture bookkeeping: an ack in the capture cycle retires the old snapshot,
  // so only a capture over a still-pending snapshot raises overrun
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      shadow     <= '0;
      count      <= '0;
      overrun    <= 1'b0;
      snap_valid <= 1'b0;
    end else begin
      if (capture) begin
        shadow <= user_data_in;
        count  <= count + 16'd1;
      end
      snap_valid <= capture || (snap_valid && !ack_req);
      if (capture && snap_valid && !ack_req) overrun <= 1'b1;
      else if (clr_req)                      overrun <= 1'b0;
    end
  end

  generate
    if (LIVE_MODE) begin : g_live
      logic [32*N_CHAN-1:0] live_q;
      // Sample the user words when a transfer is first accepted
      always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n)  live_q <= '0;
        else if (accept) live_q <= user_data_in;
      end
      assign chan_src = live_q;
    end else begin : g_shadow
      assign chan_src = shadow;
    end
  endgenerate

`ifdef OPB_REGBANK_TIMESTAMP_EN
  logic [31:0] ts_cnt, ts_q;
  // Free-running cycle counter, latched into TIMESTAMP on every capture
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (capture) ts_q <= ts_cnt;
    end
  end
  assign ts_rd = ts_q;
`else
  assign ts_rd = '0;
`endif

  // Read mux; CTRL and unmapped offsets read zero
  always_comb begin
    rdata = '0;
    if (offset == OFF_STATUS)         rdata = {snap_valid, overrun, 14'b0, count};
    else if (offset == OFF_TIMESTAMP) rdata = ts_rd;
    for (int i = 0; i < N_CHAN; i++) begin
      if (offset == OFF_CHAN_BASE + 32'(4*i)) rdata = chan_src[32*i +: 32];
    end
  end

  // Read data is driven only in the ack cycle
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) opb.sl_dbus <= '0;
    else            opb.sl_dbus <= rd_stb ? reg_to_opb(rdata) : '0;
  end

endmodule
